// File: rtl/brightness_pkg.sv
// Shared types and constants for the brightness selector.
//   btn_state_e : per-button debounce FSM state
//   DUTY_FULL   : duty code for full brightness
//   DUTY_OFF    : duty code for LED off (reset value)
//   next_duty() : saturating one-step update of the duty code
package brightness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned DUTY_W = 2;

    localparam logic [DUTY_W-1:0] DUTY_FULL = 2'b00;
    localparam logic [DUTY_W-1:0] DUTY_OFF  = 2'b11;

    // Simultaneous up/down requests cancel; the ends of the range saturate.
    function automatic logic [DUTY_W-1:0] next_duty(
        input logic [DUTY_W-1:0] cur,
        input logic              up,
        input logic              down
    );
        logic [DUTY_W-1:0] res;
        res = cur;
        if (up && !down && (cur != DUTY_FULL)) begin
            res = cur - DUTY_W'(1);
        end else if (down && !up && (cur != DUTY_OFF)) begin
            res = cur + DUTY_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/brightness_selector_if.sv
// Button / brightness bus between the user side and the selector.
//   btn_up, btn_down : raw push-buttons, 1 = pressed
//   duty_cycle       : registered brightness code (00 full on, 11 off)
//   level_changed    : one-cycle pulse when duty_cycle takes a new value
interface brightness_selector_if;
    import brightness_pkg::*;

    logic              btn_up;
    logic              btn_down;
    logic [DUTY_W-1:0] duty_cycle;
    logic              level_changed;

    modport master (
        output btn_up,
        output btn_down,
        input  duty_cycle,
        input  level_changed
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output duty_cycle,
        output level_changed
    );

endinterface

// File: rtl/btn_debounce.sv
// Synchronizer, debounce FSM and auto-repeat for one push-button.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   i_btn  : raw asynchronous button level
//   o_step : one-cycle step request (registered) on accepted press and on each repeat
module btn_debounce
    import brightness_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_step
);

    localparam int unsigned MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                                         DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_cnt_nxt;
    logic [CNT_W-1:0] w_rep_adv;
    logic             w_step_nxt;

    // Two-flop synchronizer on the raw button.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Repeat counter keeps running through a release glitch, parking at its
    // last value so the next repeat fires as soon as HELD resumes.
    assign w_rep_adv = (r_rep_cnt == REP_LAST) ? r_rep_cnt : r_rep_cnt + CNT_W'(1);

    // State, counter and step registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_db_cnt  <= '0;
            r_rep_cnt <= '0;
            o_step    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_db_cnt  <= w_db_cnt_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
            o_step    <= w_step_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_db_cnt_nxt  = r_db_cnt;
        w_rep_cnt_nxt = r_rep_cnt;
        w_step_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rep_cnt_nxt = '0;
                if (r_sync2) begin
                    w_state_nxt  = ST_PRESS_WAIT;
                    w_db_cnt_nxt = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt   = ST_HELD;
                    w_step_nxt    = 1'b1;
                    w_rep_cnt_nxt = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!r_sync2) begin
                    w_state_nxt   = ST_RELEASE_WAIT;
                    w_db_cnt_nxt  = '0;
                    w_rep_cnt_nxt = w_rep_adv;
                end else if (r_rep_cnt == REP_LAST) begin
                    w_step_nxt    = 1'b1;
                    w_rep_cnt_nxt = '0;
                end else begin
                    w_rep_cnt_nxt = w_rep_adv;
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt   = ST_HELD;
                    w_rep_cnt_nxt = w_rep_adv;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_rep_cnt_nxt = '0;
                end else begin
                    w_db_cnt_nxt  = r_db_cnt + CNT_W'(1);
                    w_rep_cnt_nxt = w_rep_adv;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/brightness_selector.sv
// Two-button brightness control producing a 2-bit PWM duty code.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : slave side of brightness_selector_if
//          (btn_up/btn_down in, duty_cycle/level_changed out)
module brightness_selector
    import brightness_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic                  clk,
    input  logic                  rst,
    brightness_selector_if.slave  bus
);

    logic              w_step_up;
    logic              w_step_down;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic [DUTY_W-1:0] r_duty;
    logic              r_level_changed;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_deb_up (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_btn  (bus.btn_up),
        .o_step (w_step_up)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_deb_down (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_btn  (bus.btn_down),
        .o_step (w_step_down)
    );

    assign w_duty_nxt = next_duty(r_duty, w_step_up, w_step_down);

    // Level register; the pulse only fires on a real change, so saturated
    // or cancelled steps stay silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty          <= DUTY_OFF;
            r_level_changed <= 1'b0;
        end else begin
            r_duty          <= w_duty_nxt;
            r_level_changed <= (w_duty_nxt != r_duty);
        end
    end

    assign bus.duty_cycle    = r_duty;
    assign bus.level_changed = r_level_changed;

endmodule

// File: doc/brightness_selector.md
BRIGHTNESS_SELECTOR -- requirements
Module: brightness_selector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, sets the consecutive stable synchronized cycles required to accept a button level change.
REQ-002 Parameter REPEAT_CYCLES, default 12500000, sets the auto-repeat interval while a button stays held.
REQ-003 Port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port btn_up, input, 1: raw asynchronous push-button, 1 = pressed; requests brighter.
REQ-006 Port btn_down, input, 1: raw asynchronous push-button, 1 = pressed; requests dimmer.
REQ-007 Port duty_cycle, output, 2: registered brightness code feeding the PWM stage; 2'b00 = full on, 2'b11 = off.
REQ-008 Port level_changed, output, 1: one-cycle pulse in the same cycle duty_cycle takes a new value.

Function
REQ-009 Each button passes through a 2-flop synchronizer before any other logic.
REQ-010 Each synchronized button drives its own debounce FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-011 IDLE -> PRESS_WAIT when the synchronized level is 1; the stability counter clears on entry.
REQ-012 PRESS_WAIT -> HELD after DEBOUNCE_CYCLES consecutive cycles at 1; it returns to IDLE on any 0 sample.
REQ-013 Entry into HELD emits one step request and clears the repeat counter.
REQ-014 In HELD, each time the repeat counter reaches REPEAT_CYCLES-1 it emits one further step request and wraps to 0.
REQ-015 HELD -> RELEASE_WAIT on a synchronized 0.
REQ-016 RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive cycles at 0; it returns to HELD on any 1 sample, without a new step request and without clearing the repeat counter.
REQ-017 Counter widths are $clog2 of the larger parameter plus 1; counters never wrap except as REQ-014 defines.
REQ-018 An up step decrements duty_cycle by 1, saturating at 2'b00.
REQ-019 A down step increments duty_cycle by 1, saturating at 2'b11.
REQ-020 When up and down step requests occur in the same cycle, both are discarded and duty_cycle holds.
REQ-021 A saturated step (no value change) produces no level_changed pulse.
REQ-022 Latency from a step request to the duty_cycle update is exactly 1 cycle; level_changed is coincident with that update.
REQ-023 Total press latency is 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle, +/-1 cycle.

Reset
REQ-024 While rst=1: duty_cycle=2'b11, level_changed=0, both FSMs in IDLE, all counters 0, synchronizer flops 0.
REQ-025 Asserting rst mid-debounce or mid-hold aborts all activity with no step emitted; a button still held at release of rst is treated as a new press and requires the full debounce.

Structure
REQ-026 A shared package brightness_pkg holds the FSM state typedef and the code constants DUTY_FULL=2'b00 and DUTY_OFF=2'b11.
REQ-027 Sub-module btn_debounce (synchronizer, FSM, repeat counter, step pulse output) is instantiated twice; brightness_selector holds only the level register and arbitration.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
REQ-028 Reset, then a btn_up pulse lasting 3 cycles -> no step; duty_cycle stays 2'b11 with no level_changed pulse.
REQ-029 Reset, then btn_up held 8 cycles and released -> duty_cycle goes 2'b11 -> 2'b10 once, with exactly one level_changed pulse.
REQ-030 btn_up held 60 cycles from 2'b11 -> steps to 2'b10, 2'b01, 2'b00 at 16-cycle spacing, then holds at 2'b00 with no further pulses.
REQ-031 btn_up and btn_down rising on the same cycle and held 8 cycles -> duty_cycle unchanged and no level_changed pulse.
REQ-032 btn_down held with a 2-cycle 0 glitch at cycle 10 of HELD -> no second press; the repeat cadence continues uninterrupted.
REQ-033 rst asserted at PRESS_WAIT cycle 3 with btn_up still held, then released -> duty_cycle=2'b11, and the first step appears a full debounce after reset release.
